bp_gshare_table: RTL

Parametrised branch direction predictor: a table of 2^IDX_W saturating counters, each CNT_W bits wide, indexed by the branch PC XOR-ed with a global history register (GHR). It generalises the single saturating counter to many counters, configurable width and history length, and adds registered lookup and a mispredict statistic. With HIST_W=0 it acts as a plain bimodal predictor. It sits beside the fetch stage: fetch issues lookups, and the execute stage returns resolved outcomes as updates.

---
 rtl/bp_gshare_table.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/bp_gshare_table.sv
// ---------------------------------------------------------------------------
// bp_gshare_table
//
// Branch direction predictor built from a table of 2^IDX_W saturating
// counters, each CNT_W bits wide. The table index is the word-aligned branch
// PC XOR-ed with a non-speculative global history register (GHR). With
// HIST_W = 0 there is no history and the table is a plain bimodal predictor.
//
// Fetch issues lookups. The registered prediction appears one cycle later.
// Execute returns resolved outcomes as updates, which train the counter
// named by upd_idx and shift the outcome into the GHR.
//
// Parameters
//   CNT_W   counter width in bits (1..4)
//   IDX_W   table index width, depth = 2^IDX_W (1..10)
//   HIST_W  GHR length, 0 = bimodal (<= IDX_W)
//   PC_W    PC width (>= IDX_W+2)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous reset, active low
//   lk_valid    lookup request
//   lk_pc       PC of the branch being looked up
//   pred_valid  registered lookup result valid
//   pred_taken  predicted direction
//   pred_idx    table index used; returned unchanged on update
//   upd_valid   resolved-branch update
//   upd_idx     index taken from the matching pred_idx
//   upd_taken   actual outcome
//   upd_pred    prediction originally made for this branch
//   misp_count  saturating count of mispredicted updates
// ---------------------------------------------------------------------------
module bp_gshare_table #(
  parameter int CNT_W  = 2,
  parameter int IDX_W  = 6,
  parameter int HIST_W = 4,
  parameter int PC_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lk_valid,
  input  logic [PC_W-1:0]  lk_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic [15:0]      misp_count
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  // Weakly not-taken: all ones below the MSB (0 for a 1-bit counter).
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [15:0]      MISP_MAX = 16'hFFFF;

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  generate
    if (CNT_W < 1 || CNT_W > 4) begin : g_bad_cnt_w
      $error("bp_gshare_table: CNT_W must be in 1..4");
    end
    if (IDX_W < 1 || IDX_W > 10) begin : g_bad_idx_w
      $error("bp_gshare_table: IDX_W must be in 1..10");
    end
    if (HIST_W < 0 || HIST_W > IDX_W) begin : g_bad_hist_w
      $error("bp_gshare_table: HIST_W must be in 0..IDX_W");
    end
    if (PC_W < IDX_W + 2) begin : g_bad_pc_w
      $error("bp_gshare_table: PC_W must be >= IDX_W+2");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Global history register
  // -------------------------------------------------------------------------
  // History folded into the low bits of the index. Upper index bits
  // (IDX_W-HIST_W of them) see zeros.
  logic [IDX_W-1:0] hist_mix;

  generate
    if (HIST_W > 0) begin : g_ghr
      logic [HIST_W-1:0] ghr_q;
      logic [HIST_W-1:0] ghr_d;

      // Truncating {ghr, taken} to HIST_W bits drops the oldest outcome and
      // puts the newest in the LSB. This also works for HIST_W == 1.
      always_comb begin
        ghr_d = ghr_q;
        if (upd_valid) begin
          ghr_d = HIST_W'({ghr_q, upd_taken});
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ghr_q <= '0;
        end else begin
          ghr_q <= ghr_d;
        end
      end

      // Lookups in the same cycle as an update use the pre-shift history.
      assign hist_mix = IDX_W'(ghr_q);
    end else begin : g_bimodal
      assign hist_mix = '0;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Lookup index
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  assign lk_idx = lk_pc[IDX_W+1:2] ^ hist_mix;

  // PC bits that never reach the index (byte offset and high bits).
  logic unused_pc_bits;
  generate
    if (PC_W > IDX_W + 2) begin : g_pc_hi
      assign unused_pc_bits = ^{lk_pc[PC_W-1:IDX_W+2], lk_pc[1:0]};
    end else begin : g_pc_exact
      assign unused_pc_bits = ^lk_pc[1:0];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Counter table
  // -------------------------------------------------------------------------
  // Kept in flops rather than block RAM: every counter must return to its
  // initial value immediately on reset, which a RAM cannot do.
  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] upd_cnt_old;
  logic [CNT_W-1:0] upd_cnt_new;

  assign upd_cnt_old = cnt_q[upd_idx];

  // Saturating step: never wraps in either direction.
  always_comb begin
    upd_cnt_new = upd_cnt_old;
    if (upd_taken) begin
      if (upd_cnt_old != CNT_MAX) begin
        upd_cnt_new = upd_cnt_old + 1'b1;
      end
    end else begin
      if (upd_cnt_old != CNT_ZERO) begin
        upd_cnt_new = upd_cnt_old - 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_q[gi] <= CNT_INIT;
        end else if (upd_valid && (upd_idx == IDX_W'(gi))) begin
          cnt_q[gi] <= upd_cnt_new;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Prediction register
  // -------------------------------------------------------------------------
  // Write-through bypass: a lookup that hits the entry being updated in the
  // same cycle predicts from the post-update counter value.
  logic [CNT_W-1:0] lk_cnt;
  logic             lk_hit_upd;

  assign lk_hit_upd = upd_valid && (upd_idx == lk_idx);
  assign lk_cnt     = lk_hit_upd ? upd_cnt_new : cnt_q[lk_idx];

  logic             pred_valid_q;
  logic             pred_valid_d;
  logic             pred_taken_q;
  logic             pred_taken_d;
  logic [IDX_W-1:0] pred_idx_q;
  logic [IDX_W-1:0] pred_idx_d;

  // Without a lookup the direction and index hold their last values; only
  // the valid flag drops.
  always_comb begin
    pred_valid_d = lk_valid;
    pred_taken_d = pred_taken_q;
    pred_idx_d   = pred_idx_q;
    if (lk_valid) begin
      pred_taken_d = lk_cnt[CNT_W-1];
      pred_idx_d   = lk_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_idx_q   <= pred_idx_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_idx   = pred_idx_q;

  // -------------------------------------------------------------------------
  // Mispredict statistic
  // -------------------------------------------------------------------------
  logic [15:0] misp_q;
  logic [15:0] misp_d;

  always_comb begin
    misp_d = misp_q;
    if (upd_valid && (upd_pred != upd_taken) && (misp_q != MISP_MAX)) begin
      misp_d = misp_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misp_q <= '0;
    end else begin
      misp_q <= misp_d;
    end
  end

  assign misp_count = misp_q;

endmodule
